// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared control constants and fetch front-end types
package fetch_unit_pkg;

   localparam int          CTL_XLEN         = 32;
   localparam logic [31:0] CTL_NOP          = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_t;

   // Sequential fetch address; wraps silently at the top of the address space.
   function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - synchronous {pc, inst} buffer with flush
module inst_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic             full;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Empty buffer presents zeros so stale entries never leak after a flush.
   assign head_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM, PC registers and imem handshake
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_consume,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_available,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  req_pc;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic [63:0]   fifo_head;
   logic          fifo_push;
   logic          fifo_pop;
   logic          accept;

   assign imem_req  = (state == S_IDLE) && (fifo_count < CW'(FIFO_DEPTH)) && !redirect && !reset;
   assign imem_addr = fetch_pc;
   assign accept    = imem_req && imem_ack;

   // Redirect wins over both the response push and the decode-side pop.
   assign fifo_push = (state == S_WAIT) && imem_rvalid && !redirect;
   assign fifo_pop  = inst_consume && inst_available && !redirect;

   assign inst_available = !fifo_empty;
   assign inst_pc        = fifo_head[63:32];
   assign inst           = fifo_head[31:0];

   inst_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_inst_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({req_pc, imem_rdata}),
      .pop       (fifo_pop),
      .flush     (redirect),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .head_data (fifo_head)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         // An outstanding request whose response has not yet arrived becomes stale.
         if (state == S_WAIT) state <= imem_rvalid ? S_IDLE : S_DISCARD;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= next_fetch_pc(fetch_pc);
                  state    <= S_WAIT;
               end
            end
            S_WAIT:    if (imem_rvalid) state <= S_IDLE;
            S_DISCARD: if (imem_rvalid) state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        inst_consume;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_available;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   int tests  = 0;
   int failed = 0;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .inst_consume   (inst_consume),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_available (inst_available),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and outputs settle 1ns later.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; inst_consume = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      next_cycle(); next_cycle(); #1;
      check("rst_req",   imem_req,       0);
      check("rst_addr",  imem_addr,      32'h0040_0000);
      check("rst_avail", inst_available, 0);
      check("rst_inst",  inst,           0);
      check("rst_pc",    inst_pc,        0);

      // Reset then fetch
      next_cycle(); reset = 1'b0; #1;
      check("c1_req",  imem_req,  1);
      check("c1_addr", imem_addr, 32'h0040_0000);
      imem_ack = 1'b1;
      next_cycle(); imem_ack = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
      check("c2_req",   imem_req,       0);
      check("c2_avail", inst_available, 0);
      next_cycle(); imem_rvalid = 1'b0; #1;
      check("c3_avail", inst_available, 1);
      check("c3_inst",  inst,           32'h0000_0013);
      check("c3_pc",    inst_pc,        32'h0040_0000);
      check("c3_req",   imem_req,       1);
      check("c3_addr",  imem_addr,      32'h0040_0004);

      // Back-pressure: second fetch fills the buffer
      imem_ack = 1'b1;
      next_cycle(); imem_ack = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0022; #1;
      next_cycle(); imem_rvalid = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         check("bp_req_low", imem_req, 0);
         check("bp_head",    inst,     32'h0000_0013);
         next_cycle(); #1;
      end
      inst_consume = 1'b1; #1;
      check("bp_req_consume", imem_req, 0);
      next_cycle(); inst_consume = 1'b0; #1;
      check("bp_req_again", imem_req,  1);
      check("bp_addr",      imem_addr, 32'h0040_0008);
      check("bp_head2",     inst,      32'h0000_0022);
      check("bp_head2_pc",  inst_pc,   32'h0040_0004);

      // Redirect while in WAIT
      imem_ack = 1'b1;
      next_cycle(); imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0103; #1;
      check("rw_req_redirect", imem_req, 0);
      next_cycle(); redirect = 1'b0; #1;
      check("rw_flushed", inst_available, 0);
      check("rw_req_d1",  imem_req,       0);
      check("rw_addr",    imem_addr,      32'h0040_0100);
      next_cycle(); #1;
      check("rw_req_d2", imem_req, 0);
      next_cycle(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
      check("rw_req_d3", imem_req, 0);
      next_cycle(); imem_rvalid = 1'b0; #1;
      check("rw_stale", inst_available, 0);
      check("rw_req",   imem_req,       1);
      check("rw_addr2", imem_addr,      32'h0040_0100);

      // Simultaneous redirect, rvalid and consume
      imem_ack = 1'b1;
      next_cycle(); imem_ack = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0AAA; #1;
      next_cycle(); imem_rvalid = 1'b0; #1;
      check("sim_inst", inst,      32'h0000_0AAA);
      check("sim_pc",   inst_pc,   32'h0040_0100);
      check("sim_addr", imem_addr, 32'h0040_0104);
      imem_ack = 1'b1;
      next_cycle();
      imem_ack = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BBB;
      inst_consume = 1'b1; redirect = 1'b1; redirect_pc = 32'h0050_0000; #1;
      check("sim_req_low", imem_req, 0);
      next_cycle(); imem_rvalid = 1'b0; inst_consume = 1'b0; redirect = 1'b0; #1;
      check("sim_avail", inst_available, 0);
      check("sim_inst0", inst,           0);
      check("sim_req",   imem_req,       1);
      check("sim_addr2", imem_addr,      32'h0050_0000);

      // Reset mid-transaction with a late response
      imem_ack = 1'b1;
      next_cycle(); imem_ack = 1'b0; reset = 1'b1; #1;
      check("rm_req_in_reset", imem_req, 0);
      next_cycle(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; #1;
      check("rm_addr", imem_addr, 32'h0040_0000);
      next_cycle(); imem_rvalid = 1'b0; #1;
      check("rm_avail", inst_available, 0);
      check("rm_req",   imem_req,       1);
      check("rm_addr2", imem_addr,      32'h0040_0000);

      // PC wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      next_cycle(); redirect = 1'b0; #1;
      check("wr_addr", imem_addr, 32'hFFFF_FFFC);
      imem_ack = 1'b1;
      next_cycle(); imem_ack = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055; #1;
      next_cycle(); imem_rvalid = 1'b0; #1;
      check("wr_pc",   inst_pc,   32'hFFFF_FFFC);
      check("wr_inst", inst,      32'h0000_0055);
      check("wr_req",  imem_req,  1);
      check("wr_next", imem_addr, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
